flex_downsample_stream: RTL and testbench

// - Streaming, runtime-configurable nearest-neighbour spatial downsampler for FDViT feature maps.
// - Consumes one CIN-channel pixel per beat in raster order (row-major, HIN x HIN).
// - Emits HOUT x HOUT selected pixels through valid/ready. Stride is a runtime Q8.8 value.
// - Sits between the token/feature buffer and the next transformer stage, replacing whole-array downsampling.

---
 rtl/flex_downsample_stream.sv | 153 +++++++++++++++
 tb/tb_flex_downsample_stream.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/flex_downsample_stream.sv
// Streaming nearest-neighbour downsampler: raster pixels in, HOUT x HOUT selected pixels out.
// Define ROUND_NEAREST_EN to select round-half-up sampling instead of floor.
module flex_downsample_stream #(
    parameter int CIN  = 64,
    parameter int DW   = 8,
    parameter int HMAX = 64,
    parameter int SW   = 16,
    parameter int CW   = $clog2(HMAX + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [SW-1:0]     cfg_stride,
    input  logic [CW-1:0]     cfg_hin,
    input  logic [CW-1:0]     cfg_hout,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CIN*DW-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CIN*DW-1:0] out_data,
    output logic              done,
    output logic              cfg_err
);
    localparam int AW   = 24;
    localparam int SELW = AW - 7;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t              state, state_nx;
    logic [SW-1:0]       stride_q;
    logic [CW-1:0]       hin_q, hout_q, hin_m1;
    logic [CW-1:0]       in_x, in_y, out_x, out_y;
    logic [AW-1:0]       acc_x, acc_y;
    logic [SELW-1:0]     sel_x, sel_y;
    logic                cfg_ok, fire, x_last, y_last, col_hit, row_hit, emit;
    logic [CIN-1:0][DW-1:0] in_pix, out_pix;

    // Accumulators pin at all-ones instead of wrapping back into range.
    function automatic logic [AW-1:0] sat_add(input logic [AW-1:0] a, input logic [SW-1:0] s);
        logic [AW:0] sum;
        sum = {1'b0, a} + {{(AW + 1 - SW){1'b0}}, s};
        return sum[AW] ? {AW{1'b1}} : sum[AW-1:0];
    endfunction

    function automatic logic [SELW-1:0] sel_of(input logic [AW-1:0] a);
`ifdef ROUND_NEAREST_EN
        return SELW'(({1'b0, a} + (AW + 1)'(128)) >> 8);
`else
        return SELW'({1'b0, a} >> 8);
`endif
    endfunction

    assign cfg_ok = (cfg_stride >= SW'(256)) && (cfg_hin != '0) && (cfg_hout != '0) &&
                    (cfg_hin <= CW'(HMAX)) && (cfg_hout <= cfg_hin);

    assign hin_m1   = hin_q - CW'(1);
    assign sel_x    = sel_of(acc_x);
    assign sel_y    = sel_of(acc_y);
    assign x_last   = (in_x == hin_m1);
    assign y_last   = (in_y == hin_m1);
    // in_x/in_y never reach hin, so a select index past the frame edge simply never matches.
    assign col_hit  = ({{(SELW - CW){1'b0}}, in_x} == sel_x) && (out_x < hout_q);
    assign row_hit  = ({{(SELW - CW){1'b0}}, in_y} == sel_y) && (out_y < hout_q);

    assign in_ready = (state == S_RUN) && (!out_valid || out_ready);
    assign fire     = in_valid && in_ready;
    assign emit     = fire && row_hit && col_hit;

    assign in_pix   = in_data;
    assign out_data = out_pix;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        done     = 1'b0;
        case (state)
            S_IDLE:  if (start && cfg_ok) state_nx = S_RUN;
            S_RUN:   if (fire && x_last && y_last) state_nx = S_DRAIN;
            S_DRAIN: if (!out_valid) begin
                state_nx = S_IDLE;
                done     = 1'b1;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) cfg_err <= 1'b0;
        else       cfg_err <= (state == S_IDLE) && start && !cfg_ok;
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            stride_q <= '0;
            hin_q    <= '0;
            hout_q   <= '0;
            in_x     <= '0;
            in_y     <= '0;
            out_x    <= '0;
            out_y    <= '0;
            acc_x    <= '0;
            acc_y    <= '0;
        end else if (state == S_IDLE) begin
            if (start && cfg_ok) begin
                stride_q <= cfg_stride;
                hin_q    <= cfg_hin;
                hout_q   <= cfg_hout;
                in_x     <= '0;
                in_y     <= '0;
                out_x    <= '0;
                out_y    <= '0;
                acc_x    <= '0;
                acc_y    <= '0;
            end
        end else if (fire) begin
            if (x_last) begin
                // Row end: column walk restarts, row accumulator advances only on a hit row.
                in_x  <= '0;
                acc_x <= '0;
                out_x <= '0;
                in_y  <= in_y + CW'(1);
                if (row_hit) begin
                    acc_y <= sat_add(acc_y, stride_q);
                    out_y <= out_y + CW'(1);
                end
            end else begin
                in_x <= in_x + CW'(1);
                if (col_hit) begin
                    acc_x <= sat_add(acc_x, stride_q);
                    out_x <= out_x + CW'(1);
                end
            end
        end
    end

    // Output register: a new hit may reload in the same cycle the old pixel leaves.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            out_valid <= 1'b0;
            out_pix   <= '0;
        end else if (emit) begin
            out_valid <= 1'b1;
            out_pix   <= in_pix;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_flex_downsample_stream.sv
// Scoreboard bench for flex_downsample_stream: model-generated expected pixels, decoupled monitor.
module tb_flex_downsample_stream;
    localparam int CIN  = 64;
    localparam int DW   = 8;
    localparam int HMAX = 64;
    localparam int SW   = 16;
    localparam int CW   = $clog2(HMAX + 1);

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              start = 1'b0;
    logic [SW-1:0]     cfg_stride = '0;
    logic [CW-1:0]     cfg_hin = '0;
    logic [CW-1:0]     cfg_hout = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [CIN*DW-1:0] in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [CIN*DW-1:0] out_data;
    logic              done;
    logic              cfg_err;

    always #5 clk = ~clk;

    flex_downsample_stream #(.CIN(CIN), .DW(DW), .HMAX(HMAX), .SW(SW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_stride(cfg_stride),
        .cfg_hin(cfg_hin), .cfg_hout(cfg_hout), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .done(done), .cfg_err(cfg_err)
    );

    logic [7:0]        exp_q[$];
    logic [7:0]        got[0:4095];
    int                vec = 0, miss = 0, done_cnt = 0, out_idx = 0;
    bit                rdy_rand = 1'b0, stall_prev = 1'b0;
    logic [CIN*DW-1:0] stall_data = '0;

    function automatic logic [CIN*DW-1:0] pix(input int r, input int c);
        logic [CIN*DW-1:0] v;
        for (int k = 0; k < CIN; k++) v[k*DW +: DW] = 8'((10 * (r + c)) % 256);
        return v;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        vec++;
        if (act != exp) begin
            miss++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: output k samples input index k*stride/256 along each axis, while inside the frame.
    task automatic push_frame(input int hin, input int hout, input int stride, output int n);
        int sel[$];
        int s;
        for (int k = 0; k < hout; k++) begin
`ifdef ROUND_NEAREST_EN
            s = (k * stride + 128) / 256;
`else
            s = (k * stride) / 256;
`endif
            if (s < hin) sel.push_back(s);
        end
        foreach (sel[y]) foreach (sel[x]) exp_q.push_back(8'((10 * (sel[y] + sel[x])) % 256));
        n = sel.size() * sel.size();
    endtask

    task automatic monitor_loop();
        logic [7:0] e;
        bit bad;
        forever begin
            @(negedge clk);
            if (rst_n) stall_prev = 1'b0;
            else begin
                if (stall_prev) begin
                    vec++;
                    if (!out_valid || out_data !== stall_data) begin
                        miss++;
                        $display("FAIL stall_hold: valid %0b data %0h expected held %0h",
                                 out_valid, out_data[7:0], stall_data[7:0]);
                    end
                end
                if (out_valid && out_ready) begin
                    vec++;
                    if (exp_q.size() == 0) begin
                        miss++;
                        $display("FAIL extra_output: got %0d expected no output", out_data[7:0]);
                    end else begin
                        e = exp_q.pop_front();
                        bad = 1'b0;
                        for (int k = 0; k < CIN; k++) if (out_data[k*DW +: DW] !== e) bad = 1'b1;
                        if (bad) begin
                            miss++;
                            $display("FAIL pixel %0d: got %0d (ch63 %0d) expected %0d",
                                     out_idx, out_data[7:0], out_data[CIN*DW-1 -: DW], e);
                        end
                    end
                    if (out_idx < 4096) got[out_idx] = out_data[7:0];
                    out_idx++;
                end
                stall_prev = out_valid && !out_ready;
                stall_data = out_data;
                if (done) begin
                    done_cnt++;
                    check("done_after_last_output", exp_q.size(), 0);
                end
            end
        end
    endtask

    task automatic ready_loop();
        forever begin
            @(posedge clk);
            #1;
            out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    endtask

    task automatic run_frame(input int hin, input int hout, input int stride, input bit rnd,
                             output int n);
        int r, c, cyc, d0;
        bit acc;
        push_frame(hin, hout, stride, n);
        out_idx    = 0;
        rdy_rand   = rnd;
        cfg_hin    = CW'(hin);
        cfg_hout   = CW'(hout);
        cfg_stride = SW'(stride);
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        r = 0; c = 0; cyc = 0; d0 = done_cnt;
        in_valid = 1'b1;
        in_data  = pix(0, 0);
        while (r < hin && cyc < 20000) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            cyc++;
            if (acc) begin
                c++;
                if (c == hin) begin c = 0; r++; end
            end
            in_valid = (r < hin) && (!rnd || $urandom_range(0, 3) != 0);
            in_data  = pix(r, c);
        end
        in_valid = 1'b0;
        while (done_cnt == d0 && cyc < 20000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        repeat (3) @(posedge clk);
        #1;
        check("frame_in_time", cyc < 20000, 1);
        check("done_once", done_cnt - d0, 1);
        check("queue_drained", exp_q.size(), 0);
        check("output_count", out_idx, n);
        rdy_rand = 1'b0;
    endtask

    task automatic cfg_bad(input int hin, input int hout, input int stride);
        cfg_hin    = CW'(hin);
        cfg_hout   = CW'(hout);
        cfg_stride = SW'(stride);
        in_valid   = 1'b1;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("cfg_err_pulse", cfg_err, 1);
        check("cfg_err_in_ready", in_ready, 0);
        @(negedge clk);
        check("cfg_err_single", cfg_err, 0);
        check("cfg_err_idle", in_ready, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        int n, c, d0;
        fork
            monitor_loop();
            ready_loop();
        join_none

        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_done", done, 0);
        check("rst_cfg_err", cfg_err, 0);
        check("rst_out_data", out_data == '0, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;

        // 27 -> 19 at stride 1.441, downstream always ready
        run_frame(27, 19, 369, 1'b0, n);
`ifdef ROUND_NEAREST_EN
        check("round_out_0_2", got[2], 30);
`else
        check("floor_out_1_2", got[21], 30);
        check("floor_out_18_18", got[360], 244);
`endif

        // same config with random backpressure and input gaps
        run_frame(27, 19, 369, 1'b1, n);

        cfg_bad(27, 30, 369);
        cfg_bad(27, 19, 200);
        cfg_bad(8, 0, 256);
        cfg_bad(70, 10, 256);

        // reset in the middle of a frame
        push_frame(27, 19, 369, n);
        cfg_hin = CW'(27); cfg_hout = CW'(19); cfg_stride = SW'(369);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        c = 0;
        in_valid = 1'b1;
        in_data  = pix(0, 0);
        repeat (60) begin
            @(negedge clk);
            if (in_ready) c++;
            @(posedge clk);
            #1;
            in_data = pix(c / 27, c % 27);
        end
        d0 = done_cnt;
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        exp_q.delete();
        rst_n = 1'b0;
        repeat (40) @(negedge clk);
        check("midrst_no_done", done_cnt - d0, 0);
        check("midrst_idle", in_ready, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;

        // stride 1.0 passes every pixel through
        run_frame(8, 8, 256, 1'b1, n);
        check("passthru_count", out_idx, 64);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
